// File: rtl/ftch_imem_ctrl.sv
// ---------------------------------------------------------------------------
// ftch_imem_ctrl
//
// Fetch-side request controller for the instruction memory. It walks the
// fetch PC sequentially, issues one word request per cycle to the imem and
// collects the in-order responses into a small circular buffer. Decode pulls
// PC/instruction pairs out of that buffer with a valid/ready handshake.
//
// The imem response channel has no backpressure. A request is therefore only
// issued when a buffer entry can be allocated for it (credit flow control).
// A pipeline redirect flushes the buffer and marks every fetch still in
// flight as stale, so that its response is discarded when it returns.
//
// Optional feature (compile-time macro FTCH_IMEM_CTRL_EPOCH_EN):
//   defined   - each request carries a 1-bit epoch tag. A redirect toggles the
//               epoch and fetching resumes immediately; stale responses are
//               recognised by their tag. A second redirect while stale
//               responses are still outstanding waits in DRAIN, because the
//               1-bit tag would alias.
//   undefined - the tag is tied to 0 and ignored on return. Any redirect that
//               leaves fetches in flight waits in DRAIN until they return.
//
// Parameters:
//   ADDR_W    fetch address width
//   DEPTH     response buffer entries (power of 2, >= 2)
//   RESET_PC  first fetch address after reset
//
// Ports:
//   clk              clock
//   reset            asynchronous active-high reset
//   redirect_vld     pipeline redirect request
//   redirect_pc      new fetch address (sampled with redirect_vld)
//   ftch_imem_vld    request valid (imem always accepts)
//   ftch_imem_addr   request address
//   ftch_imem_tag    request epoch tag
//   imem_ftch_vld    response valid (in request order)
//   imem_ftch_instr  response instruction
//   imem_ftch_tag    echoed request tag
//   ftch_dec_vld     head instruction available to decode
//   ftch_dec_rdy     decode accepts the head instruction
//   ftch_dec_pc      PC of the head instruction
//   ftch_dec_instr   head instruction
// ---------------------------------------------------------------------------
module ftch_imem_ctrl #(
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              redirect_vld,
    input  logic [ADDR_W-1:0] redirect_pc,

    output logic              ftch_imem_vld,
    output logic [ADDR_W-1:0] ftch_imem_addr,
    output logic              ftch_imem_tag,

    input  logic              imem_ftch_vld,
    input  logic [31:0]       imem_ftch_instr,
    input  logic              imem_ftch_tag,

    output logic              ftch_dec_vld,
    input  logic              ftch_dec_rdy,
    output logic [ADDR_W-1:0] ftch_dec_pc,
    output logic [31:0]       ftch_dec_instr
);

    // Index width into the buffer; pointers carry one extra wrap bit so that
    // a full buffer and an empty buffer are distinguishable.
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    // After back-to-back redirects the outstanding stale count can exceed
    // DEPTH (old-epoch stale plus the aborted new-epoch fetches).
    localparam int SW = PW + 2;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] pc;
    logic [0:0]        state;
    logic [0:0]        state_nxt;
    logic [SW-1:0]     stale;
    logic [SW-1:0]     stale_nxt;

    logic [CW-1:0]     alloc_ptr;
    logic [CW-1:0]     fill_ptr;
    logic [CW-1:0]     head_ptr;

    logic [DEPTH-1:0]  ent_filled;
    logic [ADDR_W-1:0] ent_pc    [DEPTH];
    logic [31:0]       ent_instr [DEPTH];

    logic              epoch;

    // ------------------------------------------------------------------
    // Derived occupancy
    // ------------------------------------------------------------------
    logic [CW-1:0]     occ;        // allocated, not yet popped
    logic [CW-1:0]     pending;    // allocated, response not yet returned
    logic [PW-1:0]     alloc_idx;
    logic [PW-1:0]     fill_idx;
    logic [PW-1:0]     head_idx;
    logic              head_filled;
    logic              stale_nz;

    assign occ         = alloc_ptr - head_ptr;
    assign pending     = alloc_ptr - fill_ptr;
    assign alloc_idx   = alloc_ptr[PW-1:0];
    assign fill_idx    = fill_ptr[PW-1:0];
    assign head_idx    = head_ptr[PW-1:0];
    assign head_filled = ent_filled[head_idx];
    assign stale_nz    = (stale != '0);

    // ------------------------------------------------------------------
    // Issue, response classification and pop
    // ------------------------------------------------------------------
    logic issue;
    logic rsp_drop;
    logic rsp_fill;
    logic pop;

    // reset gates the request so the port reads idle while reset is held.
    assign issue = !reset && (state == ST_RUN) && (occ != DEPTH_C) && !redirect_vld;

`ifdef FTCH_IMEM_CTRL_EPOCH_EN
    // In RUN every outstanding stale response belongs to the previous epoch.
    // In DRAIN everything in flight is stale regardless of tag, because the
    // aborted fetches may carry either tag value.
    assign rsp_drop = imem_ftch_vld && stale_nz &&
                      ((state == ST_DRAIN) || (imem_ftch_tag != epoch));
`else
    logic unused_tag;
    assign unused_tag = imem_ftch_tag;
    // Responses return in order, so while stale>0 the arriving one is stale.
    assign rsp_drop = imem_ftch_vld && stale_nz;
`endif

    assign rsp_fill = imem_ftch_vld && !rsp_drop && !redirect_vld;
    assign pop      = ftch_dec_vld && ftch_dec_rdy;

    // ------------------------------------------------------------------
    // Redirect bookkeeping
    // ------------------------------------------------------------------
    logic [SW-1:0] inflight_sum;
    logic [SW-1:0] redir_stale;
    logic [SW-1:0] old_left;

    // Everything in flight becomes stale, except the response arriving in
    // the redirect cycle itself, which is simply discarded here.
    assign inflight_sum = stale + SW'(pending);
    assign redir_stale  = (imem_ftch_vld && (inflight_sum != '0)) ?
                          inflight_sum - SW'(1) : inflight_sum;

    // Stale responses from before the previous redirect that will still be
    // outstanding after this cycle.
    assign old_left = (stale_nz && imem_ftch_vld) ? stale - SW'(1) : stale;

    always_comb begin
        stale_nxt = stale;
        state_nxt = state;
        if (redirect_vld) begin
            stale_nxt = redir_stale;
`ifdef FTCH_IMEM_CTRL_EPOCH_EN
            // Fetch can resume at once unless two epochs would be mixed.
            state_nxt = (old_left != '0) ? ST_DRAIN : ST_RUN;
`else
            state_nxt = (redir_stale != '0) ? ST_DRAIN : ST_RUN;
`endif
        end else begin
            if (rsp_drop) begin
                stale_nxt = stale - SW'(1);
            end
            if ((state == ST_DRAIN) && (stale_nxt == '0)) begin
                state_nxt = ST_RUN;
            end
        end
    end

`ifndef FTCH_IMEM_CTRL_EPOCH_EN
    logic [SW-1:0] unused_old_left;
    assign unused_old_left = old_left;
`endif

    // ------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc         <= RESET_PC;
            state      <= ST_RUN;
            stale      <= '0;
            alloc_ptr  <= '0;
            fill_ptr   <= '0;
            head_ptr   <= '0;
            ent_filled <= '0;
        end else begin
            state <= state_nxt;
            stale <= stale_nxt;
            if (redirect_vld) begin
                // Flush: pointers back to zero, all entries empty.
                pc         <= redirect_pc;
                alloc_ptr  <= '0;
                fill_ptr   <= '0;
                head_ptr   <= '0;
                ent_filled <= '0;
            end else begin
                if (issue) begin
                    pc                    <= pc + ADDR_W'(4);
                    alloc_ptr             <= alloc_ptr + CW'(1);
                    ent_filled[alloc_idx] <= 1'b0;
                end
                if (rsp_fill) begin
                    fill_ptr             <= fill_ptr + CW'(1);
                    ent_filled[fill_idx] <= 1'b1;
                end
                if (pop) begin
                    head_ptr             <= head_ptr + CW'(1);
                    ent_filled[head_idx] <= 1'b0;
                end
            end
        end
    end

`ifdef FTCH_IMEM_CTRL_EPOCH_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            epoch <= 1'b0;
        end else if (redirect_vld) begin
            epoch <= ~epoch;
        end
    end
`else
    assign epoch = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Buffer payload (no reset; validity is tracked by ent_filled)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (issue) begin
            ent_pc[alloc_idx] <= pc;
        end
        if (rsp_fill) begin
            ent_instr[fill_idx] <= imem_ftch_instr;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ftch_imem_vld  = issue;
    assign ftch_imem_addr = pc;
    assign ftch_imem_tag  = epoch;

    // Payload is masked by the fill flag so an empty head reads as zero.
    assign ftch_dec_vld   = head_filled && !redirect_vld;
    assign ftch_dec_pc    = head_filled ? ent_pc[head_idx]    : '0;
    assign ftch_dec_instr = head_filled ? ent_instr[head_idx] : '0;

endmodule

// File: tb/tb_ftch_imem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ftch_imem_ctrl
//
// Directed bench for ftch_imem_ctrl. A small imem model with programmable
// latency returns the instruction ~addr for every request, echoing its tag.
// Each scenario task drives cycles and compares against hand-derived values.
// Expectations that differ with FTCH_IMEM_CTRL_EPOCH_EN follow the same macro.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ftch_imem_ctrl;

    localparam int          ADDR_W = 32;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] RPC    = 32'h0000_0100;
`ifdef FTCH_IMEM_CTRL_EPOCH_EN
    localparam bit EPOCH = 1'b1;
`else
    localparam bit EPOCH = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_vld;
    logic [31:0] redirect_pc;
    logic        ftch_imem_vld;
    logic [31:0] ftch_imem_addr;
    logic        ftch_imem_tag;
    logic        imem_ftch_vld;
    logic [31:0] imem_ftch_instr;
    logic        imem_ftch_tag;
    logic        ftch_dec_vld;
    logic        ftch_dec_rdy;
    logic [31:0] ftch_dec_pc;
    logic [31:0] ftch_dec_instr;

    always #5 clk = ~clk;

    ftch_imem_ctrl #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_vld   (redirect_vld),
        .redirect_pc    (redirect_pc),
        .ftch_imem_vld  (ftch_imem_vld),
        .ftch_imem_addr (ftch_imem_addr),
        .ftch_imem_tag  (ftch_imem_tag),
        .imem_ftch_vld  (imem_ftch_vld),
        .imem_ftch_instr(imem_ftch_instr),
        .imem_ftch_tag  (imem_ftch_tag),
        .ftch_dec_vld   (ftch_dec_vld),
        .ftch_dec_rdy   (ftch_dec_rdy),
        .ftch_dec_pc    (ftch_dec_pc),
        .ftch_dec_instr (ftch_dec_instr)
    );

    int total = 0;
    int bad   = 0;

    // imem model: slot 0 holds the request of the previous cycle
    logic        pv [0:3];
    logic [31:0] pa [0:3];
    logic        pt [0:3];
    int          lat = 2;

    // per-cycle observations
    logic        o_rv, o_rt, o_dv;
    logic [31:0] o_ra, o_dp, o_di;

    task automatic clear_pipe();
        for (int i = 0; i < 4; i++) begin
            pv[i] = 1'b0; pa[i] = '0; pt[i] = 1'b0;
        end
    endtask

    // Called at posedge+1; returns at the next posedge+1.
    task automatic run_cycle(input logic rdy, input logic rdr, input logic [31:0] rpc);
        ftch_dec_rdy    = rdy;
        redirect_vld    = rdr;
        redirect_pc     = rpc;
        imem_ftch_vld   = pv[lat-1];
        imem_ftch_instr = ~pa[lat-1];
        imem_ftch_tag   = pt[lat-1];
        #2;
        o_rv = ftch_imem_vld; o_ra = ftch_imem_addr; o_rt = ftch_imem_tag;
        o_dv = ftch_dec_vld;  o_dp = ftch_dec_pc;    o_di = ftch_dec_instr;
        for (int i = 3; i > 0; i--) begin
            pv[i] = pv[i-1]; pa[i] = pa[i-1]; pt[i] = pt[i-1];
        end
        pv[0] = ftch_imem_vld; pa[0] = ftch_imem_addr; pt[0] = ftch_imem_tag;
        @(posedge clk); #1;
    endtask

    task automatic apply_reset(input int l);
        reset = 1'b1; redirect_vld = 1'b0; redirect_pc = '0; ftch_dec_rdy = 1'b0;
        imem_ftch_vld = 1'b0; imem_ftch_instr = '0; imem_ftch_tag = 1'b0;
        lat = l;
        clear_pipe();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        total++;
        if (ftch_imem_vld !== 1'b0 || ftch_imem_addr !== RPC || ftch_imem_tag !== 1'b0) begin
            bad++;
            $display("FAIL reset_req: vld=%b addr=%h tag=%b want vld=0 addr=%h tag=0",
                     ftch_imem_vld, ftch_imem_addr, ftch_imem_tag, RPC);
        end
        total++;
        if (ftch_dec_vld !== 1'b0 || ftch_dec_pc !== 32'h0 || ftch_dec_instr !== 32'h0) begin
            bad++;
            $display("FAIL reset_dec: vld=%b pc=%h instr=%h want 0/0/0",
                     ftch_dec_vld, ftch_dec_pc, ftch_dec_instr);
        end
    endtask

    task automatic test_streaming();
        logic [31:0] e;
        apply_reset(2);
        for (int k = 0; k < 12; k++) begin
            run_cycle(1'b1, 1'b0, '0);
            e = RPC + 32'(4 * k);
            total++;
            if (o_rv !== 1'b1 || o_ra !== e || o_rt !== 1'b0) begin
                bad++;
                $display("FAIL stream_req k=%0d: vld=%b addr=%h tag=%b want 1 %h 0", k, o_rv, o_ra, o_rt, e);
            end
            total++;
            if (k < 3) begin
                if (o_dv !== 1'b0) begin
                    bad++;
                    $display("FAIL stream_dec_early k=%0d: vld=%b want 0", k, o_dv);
                end
            end else begin
                e = RPC + 32'(4 * (k - 3));
                if (o_dv !== 1'b1 || o_dp !== e || o_di !== ~e) begin
                    bad++;
                    $display("FAIL stream_dec k=%0d: vld=%b pc=%h instr=%h want 1 %h %h", k, o_dv, o_dp, o_di, e, ~e);
                end
            end
        end
    endtask

    task automatic test_credit_limit();
        int nreq;
        logic [31:0] e;
        apply_reset(2);
        nreq = 0;
        for (int k = 0; k < 8; k++) begin
            run_cycle(1'b0, 1'b0, '0);
            if (o_rv === 1'b1) nreq++;
            if (k < 4) begin
                e = RPC + 32'(4 * k);
                total++;
                if (o_rv !== 1'b1 || o_ra !== e) begin
                    bad++;
                    $display("FAIL credit_req k=%0d: vld=%b addr=%h want 1 %h", k, o_rv, o_ra, e);
                end
            end
        end
        total++;
        if (nreq !== 4) begin
            bad++;
            $display("FAIL credit_count: got %0d requests want 4", nreq);
        end
        // single decode-ready pulse
        run_cycle(1'b1, 1'b0, '0);
        total++;
        if (o_dv !== 1'b1 || o_dp !== RPC || o_rv !== 1'b0) begin
            bad++;
            $display("FAIL credit_pulse: dec_vld=%b pc=%h req_vld=%b want 1 %h 0", o_dv, o_dp, o_rv, RPC);
        end
        nreq = 0;
        for (int k = 0; k < 5; k++) begin
            run_cycle(1'b0, 1'b0, '0);
            if (o_rv === 1'b1) nreq++;
            if (k == 0) begin
                total++;
                if (o_rv !== 1'b1 || o_ra !== RPC + 32'h10 || o_dp !== RPC + 32'h4) begin
                    bad++;
                    $display("FAIL credit_refill: vld=%b addr=%h head=%h want 1 %h %h",
                             o_rv, o_ra, o_dp, RPC + 32'h10, RPC + 32'h4);
                end
            end
        end
        total++;
        if (nreq !== 1) begin
            bad++;
            $display("FAIL credit_refill_count: got %0d requests want 1", nreq);
        end
    endtask

    task automatic test_redirect_inflight();
        int fr_k, fd_k;
        logic [31:0] fr_a, fd_p;
        logic fr_t;
        apply_reset(3);
        fr_k = -1; fd_k = -1; fr_a = '0; fd_p = '0; fr_t = 1'b0;
        for (int k = 0; k < 14; k++) begin
            run_cycle(1'b1, (k == 2), 32'h200);
            if (k == 2) begin
                total++;
                if (o_rv !== 1'b0 || o_dv !== 1'b0) begin
                    bad++;
                    $display("FAIL redir_cycle: req_vld=%b dec_vld=%b want 0 0", o_rv, o_dv);
                end
            end
            if (k > 2 && fr_k < 0 && o_rv === 1'b1) begin fr_k = k; fr_a = o_ra; fr_t = o_rt; end
            if (fd_k < 0 && o_dv === 1'b1) begin fd_k = k; fd_p = o_dp; end
        end
        total++;
        if (fr_k !== (EPOCH ? 3 : 5) || fr_a !== 32'h200 || fr_t !== EPOCH) begin
            bad++;
            $display("FAIL redir_first_req: cycle=%0d addr=%h tag=%b want %0d 200 %b",
                     fr_k, fr_a, fr_t, (EPOCH ? 3 : 5), EPOCH);
        end
        total++;
        if (fd_k !== (EPOCH ? 7 : 9) || fd_p !== 32'h200) begin
            bad++;
            $display("FAIL redir_first_dec: cycle=%0d pc=%h want %0d 200", fd_k, fd_p, (EPOCH ? 7 : 9));
        end
    endtask

    task automatic test_back_to_back();
        int fr_k, fd_k, leak;
        logic [31:0] fr_a, fd_p;
        logic fr_t;
        apply_reset(4);
        fr_k = -1; fd_k = -1; leak = 0; fr_a = '0; fd_p = '0; fr_t = 1'b0;
        for (int k = 0; k < 17; k++) begin
            run_cycle(1'b1, (k == 3) || (k == 5), (k == 3) ? 32'h200 : 32'h300);
            if (k == 4) begin
                total++;
                if (o_rv !== EPOCH || (EPOCH && (o_ra !== 32'h200 || o_rt !== 1'b1))) begin
                    bad++;
                    $display("FAIL b2b_mid_req: vld=%b addr=%h tag=%b want vld=%b", o_rv, o_ra, o_rt, EPOCH);
                end
            end
            if (k > 5 && fr_k < 0 && o_rv === 1'b1) begin fr_k = k; fr_a = o_ra; fr_t = o_rt; end
            if (fd_k < 0 && o_dv === 1'b1) begin fd_k = k; fd_p = o_dp; end
            if (o_dv === 1'b1 && o_dp < 32'h300) leak++;
        end
        total++;
        if (fr_k !== (EPOCH ? 9 : 7) || fr_a !== 32'h300 || fr_t !== 1'b0) begin
            bad++;
            $display("FAIL b2b_first_req: cycle=%0d addr=%h tag=%b want %0d 300 0", fr_k, fr_a, fr_t, (EPOCH ? 9 : 7));
        end
        total++;
        if (fd_k !== (EPOCH ? 14 : 12) || fd_p !== 32'h300 || leak !== 0) begin
            bad++;
            $display("FAIL b2b_first_dec: cycle=%0d pc=%h leaks=%0d want %0d 300 0",
                     fd_k, fd_p, leak, (EPOCH ? 14 : 12));
        end
    endtask

    task automatic test_redirect_pop();
        int fr_k, fd_k, nreq;
        logic [31:0] fr_a, fd_p;
        apply_reset(2);
        for (int k = 0; k < 3; k++) run_cycle(1'b1, 1'b0, '0);
        // cycle 3: head 0x100 filled, response for 0x104 arriving, rdy=1
        run_cycle(1'b1, 1'b1, 32'h400);
        total++;
        if (o_dv !== 1'b0 || o_rv !== 1'b0) begin
            bad++;
            $display("FAIL rpop_cycle: dec_vld=%b req_vld=%b want 0 0", o_dv, o_rv);
        end
        fr_k = -1; fd_k = -1; nreq = 0; fr_a = '0; fd_p = '0;
        for (int k = 4; k < 16; k++) begin
            run_cycle(1'b0, 1'b0, '0);
            if (k == 4) begin
                total++;
                if (o_dv !== 1'b0 || o_dp !== 32'h0) begin
                    bad++;
                    $display("FAIL rpop_flushed: dec_vld=%b pc=%h want 0 0", o_dv, o_dp);
                end
            end
            if (o_rv === 1'b1) nreq++;
            if (fr_k < 0 && o_rv === 1'b1) begin fr_k = k; fr_a = o_ra; end
            if (fd_k < 0 && o_dv === 1'b1) begin fd_k = k; fd_p = o_dp; end
        end
        total++;
        if (fr_k !== (EPOCH ? 4 : 5) || fr_a !== 32'h400 || nreq !== 4) begin
            bad++;
            $display("FAIL rpop_req: cycle=%0d addr=%h count=%0d want %0d 400 4", fr_k, fr_a, nreq, (EPOCH ? 4 : 5));
        end
        total++;
        if (fd_k !== (EPOCH ? 7 : 8) || fd_p !== 32'h400) begin
            bad++;
            $display("FAIL rpop_dec: cycle=%0d pc=%h want %0d 400", fd_k, fd_p, (EPOCH ? 7 : 8));
        end
    endtask

    task automatic test_async_reset();
        apply_reset(2);
        for (int k = 0; k < 5; k++) run_cycle(1'b1, 1'b0, '0);
        total++;
        if (o_dv !== 1'b1) begin
            bad++;
            $display("FAIL areset_pre: dec_vld=%b want 1", o_dv);
        end
        #2;
        reset = 1'b1;
        imem_ftch_vld = 1'b0; ftch_dec_rdy = 1'b0;
        #1;
        total++;
        if (ftch_imem_vld !== 1'b0 || ftch_imem_addr !== RPC || ftch_imem_tag !== 1'b0) begin
            bad++;
            $display("FAIL areset_req: vld=%b addr=%h tag=%b want 0 %h 0", ftch_imem_vld, ftch_imem_addr, ftch_imem_tag, RPC);
        end
        total++;
        if (ftch_dec_vld !== 1'b0 || ftch_dec_pc !== 32'h0 || ftch_dec_instr !== 32'h0) begin
            bad++;
            $display("FAIL areset_dec: vld=%b pc=%h instr=%h want 0 0 0", ftch_dec_vld, ftch_dec_pc, ftch_dec_instr);
        end
        clear_pipe();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        run_cycle(1'b1, 1'b0, '0);
        total++;
        if (o_rv !== 1'b1 || o_ra !== RPC) begin
            bad++;
            $display("FAIL areset_first: vld=%b addr=%h want 1 %h", o_rv, o_ra, RPC);
        end
        run_cycle(1'b1, 1'b0, '0);
        total++;
        if (o_rv !== 1'b1 || o_ra !== RPC + 32'h4) begin
            bad++;
            $display("FAIL areset_second: vld=%b addr=%h want 1 %h", o_rv, o_ra, RPC + 32'h4);
        end
    endtask

    initial begin
        reset = 1'b1; redirect_vld = 1'b0; redirect_pc = '0; ftch_dec_rdy = 1'b0;
        imem_ftch_vld = 1'b0; imem_ftch_instr = '0; imem_ftch_tag = 1'b0;
        clear_pipe();
        test_reset();
        test_streaming();
        test_credit_limit();
        test_redirect_inflight();
        test_back_to_back();
        test_redirect_pop();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
